// File: rtl/button_pkg.sv
// Shared definitions for the button lockout / toggle block.
//   lockout_state_t : per-button FSM state (IDLE, LOCKOUT)
//   popcount()      : number of set bits in a button vector (up to MAX_BUTTONS)
//   CLOCK_FREQ_HZ   : system clock of the lab designs
package button_pkg;

  localparam int unsigned CLOCK_FREQ_HZ = 50_000_000;
  localparam int unsigned MAX_BUTTONS   = 8;
  localparam int unsigned POP_W         = $clog2(MAX_BUTTONS + 1);

  typedef enum logic {
    IDLE,
    LOCKOUT
  } lockout_state_t;

  function automatic logic [POP_W-1:0] popcount(input logic [MAX_BUTTONS-1:0] bits);
    logic [POP_W-1:0] n;
    n = '0;
    for (int i = 0; i < MAX_BUTTONS; i++) begin
      n = n + POP_W'(bits[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/button_lockout.sv
// One button's lockout FSM, lockout counter and LED toggle bit.
//   clock          : system clock
//   reset_n        : asynchronous active-low reset
//   button_pressed : one-cycle press event
//   led            : toggle state, inverts on each accepted press
//   press_accepted : registered one-cycle pulse after an accepted press
//   accept         : combinational "press accepted at this edge", used by the
//                    parent to update the total count with the same latency
module button_lockout
  import button_pkg::*;
#(
  parameter int unsigned LOCKOUT_CYCLES = 5_000_000
) (
  input  logic clock,
  input  logic reset_n,
  input  logic button_pressed,
  output logic led,
  output logic press_accepted,
  output logic accept
);

  localparam int unsigned CNT_W = $clog2(LOCKOUT_CYCLES + 1);

  lockout_state_t   state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             led_d;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    state_d = state_q;
    cnt_d   = cnt_q;
    led_d   = led;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (button_pressed) begin
          accept  = 1'b1;
          led_d   = ~led;
          cnt_d   = CNT_W'(LOCKOUT_CYCLES);
          state_d = LOCKOUT;
        end
      end
      LOCKOUT: begin
        // Presses are simply ignored here; leave at the 1 -> 0 step so the
        // window covers exactly LOCKOUT_CYCLES edges after the accepting one.
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // NOTE: the asynchronous reset clears every register, including the lockout
  // counter, so a reset mid-window never carries the lockout over.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      led            <= 1'b0;
      press_accepted <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers
      // update together from the values sampled at this edge.
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      led            <= led_d;
      press_accepted <= accept;
    end
  end

endmodule

// File: rtl/button_lockout_toggle.sv
// Per-button press lockout with LED toggle and a wrapping accepted-press count.
//   clock          : 50 MHz system clock
//   reset_n        : asynchronous active-low reset (synchronized upstream)
//   button_pressed : one-cycle press events, one bit per button
//   clear_count    : synchronous clear of press_count, wins over same-edge presses
//   led            : toggle state per button
//   press_accepted : one-cycle pulse per accepted press
//   press_count    : total accepted presses modulo 2^COUNT_WIDTH
module button_lockout_toggle
  import button_pkg::*;
#(
  parameter int unsigned NUM_BUTTONS    = 1,
  parameter int unsigned LOCKOUT_CYCLES = CLOCK_FREQ_HZ / 10,  // 100 ms
  parameter int unsigned COUNT_WIDTH    = 8
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [NUM_BUTTONS-1:0] button_pressed,
  input  logic                   clear_count,
  output logic [NUM_BUTTONS-1:0] led,
  output logic [NUM_BUTTONS-1:0] press_accepted,
  output logic [COUNT_WIDTH-1:0] press_count
);

  logic [NUM_BUTTONS-1:0] accept;
  logic [MAX_BUTTONS-1:0] accept_ext;

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    button_lockout #(
      .LOCKOUT_CYCLES(LOCKOUT_CYCLES)
    ) u_button_lockout (
      .clock          (clock),
      .reset_n        (reset_n),
      .button_pressed (button_pressed[i]),
      .led            (led[i]),
      .press_accepted (press_accepted[i]),
      .accept         (accept[i])
    );
  end

  assign accept_ext = MAX_BUTTONS'(accept);

  // Counting the same-edge accepts keeps press_count in step with led and
  // press_accepted; the natural wrap of the adder gives the modulo behaviour.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      press_count <= '0;
    end else if (clear_count) begin
      press_count <= '0;
    end else begin
      press_count <= press_count + COUNT_WIDTH'(popcount(accept_ext));
    end
  end

endmodule

// File: tb/tb_button_lockout_toggle.sv
module tb_button_lockout_toggle;

  localparam int NB = 3;
  localparam int LC = 4;
  localparam int CW = 8;

  logic          clock;
  logic          reset_n;
  logic [NB-1:0] button_pressed;
  logic          clear_count;
  logic [NB-1:0] led;
  logic [NB-1:0] press_accepted;
  logic [CW-1:0] press_count;

  int checks   = 0;
  int failures = 0;

  // Reference model: a press is accepted unless this button accepted a press
  // within the previous LC edges.
  int            edge_n;
  int            last_acc [NB];
  bit            have_last[NB];
  logic [NB-1:0] led_m;
  logic [NB-1:0] acc_m;
  int            count_m;

  button_lockout_toggle #(
    .NUM_BUTTONS   (NB),
    .LOCKOUT_CYCLES(LC),
    .COUNT_WIDTH   (CW)
  ) dut (
    .clock         (clock),
    .reset_n       (reset_n),
    .button_pressed(button_pressed),
    .clear_count   (clear_count),
    .led           (led),
    .press_accepted(press_accepted),
    .press_count   (press_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) have_last[i] = 1'b0;
    led_m   = '0;
    acc_m   = '0;
    count_m = 0;
  endtask

  task automatic model_edge(input logic [NB-1:0] b, input logic c);
    int n;
    n = 0;
    edge_n++;
    acc_m = '0;
    for (int i = 0; i < NB; i++) begin
      if (b[i] && (!have_last[i] || (edge_n - last_acc[i]) > LC)) begin
        acc_m[i]     = 1'b1;
        led_m[i]     = ~led_m[i];
        last_acc[i]  = edge_n;
        have_last[i] = 1'b1;
        n++;
      end
    end
    count_m = c ? 0 : (count_m + n) % (1 << CW);
  endtask

  task automatic compare_all(input string tag);
    check({tag, ".led"}, 32'(led), 32'(led_m));
    check({tag, ".acc"}, 32'(press_accepted), 32'(acc_m));
    check({tag, ".cnt"}, 32'(press_count), 32'(count_m));
  endtask

  // Drive inputs, take one edge, update the model, compare 1 time unit later.
  task automatic step(input logic [NB-1:0] b, input logic c, input string tag);
    button_pressed = b;
    clear_count    = c;
    @(posedge clock);
    model_edge(b, c);
    #1;
    compare_all(tag);
    button_pressed = '0;
    clear_count    = 1'b0;
  endtask

  // Asynchronous reset in the middle of a cycle, held for two edges.
  task automatic pulse_reset(input string tag);
    reset_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".led"}, 32'(led), 32'(0));
    check({tag, ".acc"}, 32'(press_accepted), 32'(0));
    check({tag, ".cnt"}, 32'(press_count), 32'(0));
    repeat (2) @(posedge clock);
    #1;
    check({tag, ".held_led"}, 32'(led), 32'(0));
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    reset_n        = 1'b0;
    button_pressed = '0;
    clear_count    = 1'b0;
    edge_n         = 0;
    model_reset();
    #23;
    check("rst.led", 32'(led), 32'(0));
    check("rst.cnt", 32'(press_count), 32'(0));
    reset_n = 1'b1;

    // Idle after reset: everything stays at zero.
    for (int i = 0; i < 10; i++) begin
      step('0, 1'b0, "idle");
      check("idle.led0", 32'(led), 32'(0));
      check("idle.cnt0", 32'(press_count), 32'(0));
    end

    // Single press, lockout window of LC edges, then the next press counts.
    step(3'b001, 1'b0, "press1");
    check("press1.led_c", 32'(led), 32'(3'b001));
    check("press1.acc_c", 32'(press_accepted), 32'(3'b001));
    for (int i = 0; i < LC; i++) begin
      step(3'b001, 1'b0, "lockout");
      check("lockout.acc_c", 32'(press_accepted), 32'(0));
      check("lockout.led_c", 32'(led), 32'(3'b001));
    end
    step(3'b001, 1'b0, "press2");
    check("press2.led_c", 32'(led), 32'(0));
    check("press2.cnt_c", 32'(press_count), 32'(2));

    // Simultaneous presses on buttons 0 and 2.
    repeat (LC) step('0, 1'b0, "gap");
    step(3'b101, 1'b0, "dual");
    check("dual.led_c", 32'(led), 32'(3'b101));
    check("dual.acc_c", 32'(press_accepted), 32'(3'b101));
    check("dual.cnt_c", 32'(press_count), 32'(4));
    step('0, 1'b0, "dual_end");
    check("dual_end.acc_c", 32'(press_accepted), 32'(0));

    // Clear, then 256 presses wrap the counter back to zero.
    step('0, 1'b1, "clear");
    check("clear.cnt_c", 32'(press_count), 32'(0));
    for (int i = 0; i < 256; i++) begin
      step(3'b010, 1'b0, "wrap_p");
      repeat (5) step('0, 1'b0, "wrap_g");
    end
    check("wrap.cnt_c", 32'(press_count), 32'(0));
    check("wrap.led_c", 32'(led), 32'(3'b101));

    // Bring count to 7, then clear on the same edge as a press.
    for (int i = 0; i < 7; i++) begin
      step(3'b010, 1'b0, "seven_p");
      repeat (5) step('0, 1'b0, "seven_g");
    end
    check("seven.cnt_c", 32'(press_count), 32'(7));
    step(3'b010, 1'b1, "clr_press");
    check("clr_press.cnt_c", 32'(press_count), 32'(0));
    check("clr_press.led_c", 32'(led), 32'(3'b101));
    check("clr_press.acc_c", 32'(press_accepted), 32'(3'b010));

    // Reset mid-lockout; a press on the first edge afterwards is accepted.
    repeat (5) step('0, 1'b0, "pre_rst");
    step(3'b001, 1'b0, "rst_press");
    step('0, 1'b0, "rst_mid");
    step('0, 1'b0, "rst_mid");
    pulse_reset("midrst");
    step(3'b001, 1'b0, "post_rst");
    check("post_rst.led_c", 32'(led), 32'(3'b001));
    check("post_rst.acc_c", 32'(press_accepted), 32'(3'b001));
    check("post_rst.cnt_c", 32'(press_count), 32'(1));

    // Randomized traffic, including held inputs, clears and resets.
    for (int i = 0; i < 3000; i++) begin
      logic [NB-1:0] b;
      logic          c;
      for (int j = 0; j < NB; j++) b[j] = ($urandom_range(0, 2) == 0);
      c = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 499) == 0) pulse_reset("rand_rst");
      step(b, c, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
